// File: rtl/gray_mul_seq_pkg.sv
// Shared constants for the RGB-to-gray sequencer: FSM encoding, default
// luma weights, accumulator width and the output saturation helper.
package gray_mul_seq_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S_R  = 3'd1;
  localparam logic [2:0] S_G  = 3'd2;
  localparam logic [2:0] S_B  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [7:0] WR_DEF_C = 8'd77;
  localparam logic [7:0] WG_DEF_C = 8'd150;
  localparam logic [7:0] WB_DEF_C = 8'd29;

  localparam int ACC_W = 26;

  // acc holds sum*256, so bits [25:16] are the gray value before clamping
  function automatic logic [7:0] sat_gray(input logic [ACC_W-1:0] acc);
    return (acc[25:16] > 10'd255) ? 8'd255 : acc[23:16];
  endfunction

endpackage

// File: rtl/gray_mul_seq_mul.sv
// Shared 8x8 multiplier; the product is pre-scaled by 256 so the
// accumulator carries eight extra fraction bits.
module gray_mul_seq_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [23:0] p
);

  logic [15:0] prod;

  assign prod = a * b;
  assign p    = {prod, 8'h00};

endmodule

// File: rtl/gray_mul_seq.sv
// RGB-to-grayscale sequencer: one multiplier reused over three cycles per
// pixel, valid/ready on both sides, runtime-writable channel weights.
//
//   state | meaning
//   IDLE  | waiting for a pixel, multiplier idle
//   S_R   | acc <= R*wr
//   S_G   | acc += G*wg
//   S_B   | acc += B*wb
//   DONE  | result presented; may accept the next pixel on handshake
module gray_mul_seq
  import gray_mul_seq_pkg::*;
#(
  parameter logic [7:0] WR_DEF = WR_DEF_C,
  parameter logic [7:0] WG_DEF = WG_DEF_C,
  parameter logic [7:0] WB_DEF = WB_DEF_C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       cfg_we,
  input  logic [7:0] cfg_wr,
  input  logic [7:0] cfg_wg,
  input  logic [7:0] cfg_wb,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_gray
);

  logic [2:0]       state;
  logic [7:0]       pix_r, pix_g, pix_b;
  logic [7:0]       snap_wr, snap_wg, snap_wb;
  logic [7:0]       live_wr, live_wg, live_wb;
  logic [ACC_W-1:0] acc;

  logic [7:0]       mul_a, mul_b;
  logic [23:0]      mul_p;
  logic [ACC_W-1:0] mul_ext;
  logic             take;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign take      = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign out_gray  = sat_gray(acc);
  assign mul_ext   = {2'b00, mul_p};

  always_comb begin
    mul_a = 8'd0;
    mul_b = 8'd0;
    case (state)
      S_R: begin mul_a = pix_r; mul_b = snap_wr; end
      S_G: begin mul_a = pix_g; mul_b = snap_wg; end
      S_B: begin mul_a = pix_b; mul_b = snap_wb; end
      default: ;
    endcase
  end

  gray_mul_seq_mul u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      pix_r   <= 8'd0;
      pix_g   <= 8'd0;
      pix_b   <= 8'd0;
      snap_wr <= WR_DEF;
      snap_wg <= WG_DEF;
      snap_wb <= WB_DEF;
      live_wr <= WR_DEF;
      live_wg <= WG_DEF;
      live_wb <= WB_DEF;
    end else begin
      if (cfg_we) begin
        live_wr <= cfg_wr;
        live_wg <= cfg_wg;
        live_wb <= cfg_wb;
      end
      // snapshot reads the pre-write weights when cfg_we coincides with a take
      if (take) begin
        pix_r   <= in_r;
        pix_g   <= in_g;
        pix_b   <= in_b;
        snap_wr <= live_wr;
        snap_wg <= live_wg;
        snap_wb <= live_wb;
      end
      case (state)
        IDLE: if (take) state <= S_R;
        S_R: begin
          acc   <= mul_ext;
          state <= S_G;
        end
        S_G: begin
          acc   <= acc + mul_ext;
          state <= S_B;
        end
        S_B: begin
          acc   <= acc + mul_ext;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= take ? S_R : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_mul_seq.sv
// Scoreboard bench for gray_mul_seq: expected gray values are pushed at
// input handshake and popped by an independent output monitor.
module tb_gray_mul_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_r, in_g, in_b;
  logic       cfg_we;
  logic [7:0] cfg_wr, cfg_wg, cfg_wb;
  logic       out_valid, out_ready;
  logic [7:0] out_gray;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int cyc = 0;
  int mwr = 77, mwg = 150, mwb = 29;
  bit rand_ready = 1'b0;
  int hs_cyc = 0;
  int last_out_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .cfg_we    (cfg_we),
    .cfg_wr    (cfg_wr),
    .cfg_wg    (cfg_wg),
    .cfg_wb    (cfg_wb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_gray(input int r, g, b, wr, wg, wb);
    int s;
    s = (r * wr + g * wg + b * wb) / 256;
    return (s > 255) ? 255 : s;
  endfunction

  // entered and left on a negedge; inputs sampled 1ns before each posedge
  task automatic send(input int r, g, b, input bit we, input int wr, wg, wb,
                      output int waits);
    bit done = 1'b0;
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    cfg_wr = 8'(wr); cfg_wg = 8'(wg); cfg_wb = 8'(wb);
    cfg_we = we;
    in_valid = 1'b1;
    waits = 0;
    for (int n = 0; n < 60; n++) begin
      #4;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_gray(r, g, b, mwr, mwg, mwb));
        hs_cyc = cyc;
        if (cfg_we) begin mwr = wr; mwg = wg; mwb = wb; end
        done = 1'b1;
        @(negedge clk);
        break;
      end
      if (cfg_we) begin mwr = wr; mwg = wg; mwb = wb; end
      @(negedge clk);
      cfg_we = 1'b0;
      waits++;
    end
    chk("send_timeout", int'(done), 1);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_write(input int wr, wg, wb);
    cfg_wr = 8'(wr); cfg_wg = 8'(wg); cfg_wb = 8'(wb);
    cfg_we = 1'b1;
    #4;
    mwr = wr; mwg = wg; mwb = wb;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // output monitor: compare on handshake, hold stability while stalled
  initial begin
    bit stall = 1'b0;
    logic [7:0] held = 8'd0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        stall = 1'b0;
      end else if (out_valid) begin
        if (stall) chk("hold_stable", out_gray, held);
        if (out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", exp_q.size(), 1);
          else begin
            chk("gray", out_gray, exp_q.pop_front());
            last_out_cyc = cyc;
          end
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held  = out_gray;
        end
      end else if (stall) begin
        chk("valid_dropped", out_valid, 1);
        stall = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int w;
    int first;
    rst = 1'b1; in_valid = 1'b0; in_r = 0; in_g = 0; in_b = 0;
    cfg_we = 1'b0; cfg_wr = 0; cfg_wg = 0; cfg_wb = 0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gray", out_gray, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // latency: white pixel with default weights
    send(255, 255, 255, 1'b0, 0, 0, 0, w);
    for (int i = 1; i <= 3; i++) begin
      #4;
      chk("lat_in_ready", in_ready, 0);
      chk("lat_out_valid_low", out_valid, 0);
      @(negedge clk);
    end
    #4;
    chk("lat_out_valid_high", out_valid, 1);
    @(negedge clk);
    wait_drain();

    send(100, 0, 0, 1'b0, 0, 0, 0, w);
    send(0, 0, 200, 1'b0, 0, 0, 0, w);
    wait_drain();

    // back-to-back stream
    send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
         1'b0, 0, 0, 0, w);
    first = hs_cyc;
    for (int i = 1; i < 8; i++)
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           1'b0, 0, 0, 0, w);
    wait_drain();
    chk("stream_cycles", last_out_cyc - first, 32);

    cfg_write(255, 255, 255);
    send(255, 255, 255, 1'b0, 0, 0, 0, w);
    send(1, 1, 1, 1'b0, 0, 0, 0, w);
    wait_drain();

    // weight write coinciding with accept: pixel uses old weights
    send(255, 255, 255, 1'b1, 0, 0, 0, w);
    send(255, 255, 255, 1'b0, 0, 0, 0, w);
    wait_drain();
    cfg_write(77, 150, 29);

    // output stall with a pending pixel
    out_ready = 1'b0;
    send(10, 20, 30, 1'b0, 0, 0, 0, w);
    in_r = 8'd40; in_g = 8'd50; in_b = 8'd60; in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #4;
      if (out_valid) break;
      @(negedge clk);
    end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #4;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(40, 50, 60, 1'b0, 0, 0, 0, w);
    chk("pending_accept_waits", w, 0);
    wait_drain();

    // reset during S_G aborts the pixel and restores default weights
    cfg_write(10, 20, 30);
    send(200, 100, 50, 1'b0, 0, 0, 0, w);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    mwr = 77; mwg = 150; mwb = 29;
    #4;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    repeat (6) @(negedge clk);
    send(255, 255, 255, 1'b0, 0, 0, 0, w);
    send(100, 0, 0, 1'b0, 0, 0, 0, w);
    wait_drain();

    // randomized traffic with random backpressure and weight writes
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           ($urandom_range(0, 5) == 0), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255), w);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_mul_seq.md
# gray_mul_seq

Time-multiplexed RGB-to-grayscale sequencer that drives a single shared 8×8 multiplier (`MUL`: 24-bit result = a·b·256) through three weighted products per pixel. It accumulates Y = (R·wr + G·wg + B·wb) >> 8. It sits between the pixel source and the gray-image sink in the image-processing pipeline. Input and output use valid/ready handshakes, and weights are runtime-configurable.

## Interface
Parameters:
- `WR_DEF`, 8'd77: reset value of the R weight
- `WG_DEF`, 8'd150: reset value of the G weight
- `WB_DEF`, 8'd29: reset value of the B weight

Ports:
- Clocking: single clock `clk`; reset `rst` is synchronous, active-high.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  pixel offered
- `in_ready`  out  1  block accepts pixel this cycle
- `in_r`, `in_g`, `in_b`  in  8 each  pixel channels
- `cfg_we`  in  1  weight write strobe
- `cfg_wr`, `cfg_wg`, `cfg_wb`  in  8 each  new weights
- `out_valid`  out  1  gray result available
- `out_ready`  in  1  sink accepts result
- `out_gray`  out  8  saturated gray value

## Operation
- FSM states: IDLE, S_R, S_G, S_B, DONE.
- Accept: `in_ready = (state==IDLE) | (state==DONE & out_ready)`. A transfer (`in_valid & in_ready`) latches R/G/B and a snapshot of the three live weights, then moves to S_R.
- S_R: MUL a=R, b=wr; acc <= product (zero-extended to 26 bits); next S_G.
- S_G: MUL a=G, b=wg; acc <= acc + product; next S_B.
- S_B: MUL a=B, b=wb; acc <= acc + product; next DONE.
- DONE: `out_valid=1`.
  - `out_ready=1` with a new input transfer → S_R.
  - `out_ready=1` without one → IDLE.
  - `out_ready=0` → stay in DONE; `out_gray` holds stable.
- Arithmetic:
  - acc is 26 bits; maximum 255·765·256 < 2^26, so acc never wraps.
  - `out_gray = (acc[25:16] > 255) ? 8'd255 : acc[23:16]`, i.e. truncating divide by 65536 with saturation.
- Config:
  - `cfg_we` writes all three live weight registers in any state.
  - An in-flight pixel always uses its snapshot.
  - If `cfg_we` and an input transfer occur in the same cycle, that pixel gets the OLD weights.
- MUL inputs are driven to 0 in IDLE and DONE.

## Timing
- Reset values:
  - state IDLE; acc 0; latched pixel 0
  - weights = WR_DEF/WG_DEF/WB_DEF
  - `out_valid=0`, `out_gray=0`, `in_ready=1`
- Latency:
  - Transfer on edge k → `out_valid` high from cycle k+4.
  - Throughput is 1 pixel per 4 cycles with `out_ready` held high (DONE overlaps accept).
- `in_ready` is low in S_R/S_G/S_B. `in_valid` during those states is ignored, not dropped: the source holds it.
- Reset mid-operation aborts the pixel: the next cycle shows `out_valid=0` and state IDLE, with no partial result emitted.
- `out_valid` never drops without an `out_ready` handshake.

## Structure
- Shared package holds:
  - FSM state encoding (3-bit localparams IDLE=0, S_R=1, S_G=2, S_B=3, DONE=4)
  - default weight constants
  - acc width constant 26
- One sub-module: a single `MUL` instance (combinational) is the only multiplier. No other multiply operator is allowed in the block.
- Registers: state, pixel latch (24b), weight snapshot (24b), live weights (24b), acc (26b).

## Test plan
- Defaults, R=G=B=255, `out_ready=1` → `out_gray=255` exactly 4 cycles after accept; `in_ready` low for 3 cycles.
- Defaults, R=100, G=0, B=0 → 30; then R=0, G=0, B=200 → 22 (5800>>8). Back-to-back stream of 8 pixels completes in 32 cycles.
- `cfg_we` with weights 255/255/255, then R=G=B=255 → saturated 255. Same weights with R=G=B=1 → 2 (765>>8).
- `cfg_we` to 0/0/0 asserted in the same cycle as a transfer of R=G=B=255 → that pixel gives 255 (old weights); the next identical pixel gives 0.
- `out_ready` low for 10 cycles in DONE → `out_valid` and `out_gray` stable, `in_ready=0`. Release → handshake, and the pending input is accepted that same cycle.
- `rst` asserted during S_G → next cycle `out_valid=0` and `in_ready=1`, weights back to defaults; no result appears for the aborted pixel.
